guess_history_buf: RTL

//  Parametrised turn-history store for the guessing game. Each btn_select pulse in guess

---
 rtl/guess_history_buf.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/guess_history_buf.sv
// Turn-history store for the guessing game.
// Records one guess per btn_select in guess mode and lets the player browse the
// stored turns with btn_up/btn_down in history mode. Logical turn 0 is always the
// oldest stored guess.
// Optional feature: define HISTORY_WRAP_EN to let a select while full overwrite the
// oldest turn (ring behaviour). Without it, selects while full are dropped and the
// oldest pointer is tied to 0.
module guess_history_buf #(
  parameter int PEGS    = 4,
  parameter int COLOR_W = 3,
  parameter int DEPTH   = 8,
  localparam int TURN_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_select,
  input  logic [PEGS*COLOR_W-1:0]   guess,
  output logic [PEGS*COLOR_W-1:0]   selection,
  output logic [TURN_W-1:0]         selected_turn,
  output logic [TURN_W:0]           turn_count,
  output logic                      last_turn,
  output logic                      full
);

  localparam int                GW        = PEGS * COLOR_W;
  localparam logic [TURN_W-1:0] LAST_SLOT = TURN_W'(DEPTH - 1);
  localparam logic [TURN_W:0]   DEPTH_CNT = (TURN_W + 1)'(DEPTH);
  localparam logic [TURN_W:0]   LAST_CNT  = (TURN_W + 1)'(DEPTH - 1);

  logic [GW-1:0]     mem [DEPTH];
  logic [TURN_W-1:0] wr_ptr;
  logic [TURN_W-1:0] oldest_ptr;

  logic [TURN_W:0]   tc_next;
  logic [TURN_W-1:0] turn_next;
  logic [TURN_W-1:0] tc_minus1;
  logic [TURN_W-1:0] read_slot;
  logic              wr_en;
  logic              load_guess;
  logic              read_en;
  logic              clear_sel;
`ifdef HISTORY_WRAP_EN
  logic              wrap_en;
`endif

  // Maps a logical turn to its physical slot: (base + k) mod DEPTH.
  function automatic logic [TURN_W-1:0] phys_slot(input logic [TURN_W-1:0] base,
                                                  input logic [TURN_W-1:0] k);
    logic [TURN_W:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= DEPTH_CNT) sum = sum - DEPTH_CNT;
    return sum[TURN_W-1:0];
  endfunction

  // Newest logical turn; low bits of turn_count still give DEPTH-1 when full.
  assign tc_minus1 = turn_count[TURN_W-1:0] - 1'b1;
  assign read_slot = phys_slot(oldest_ptr, turn_next);

  // Decide the next turn count, displayed turn and how selection is refreshed.
  always_comb begin
    tc_next    = turn_count;
    turn_next  = selected_turn;
    wr_en      = 1'b0;
    load_guess = 1'b0;
    read_en    = 1'b0;
    clear_sel  = 1'b0;
`ifdef HISTORY_WRAP_EN
    wrap_en    = 1'b0;
`endif
    if (!mode) begin
      if (btn_select && !full) begin
        wr_en      = 1'b1;
        load_guess = 1'b1;
        tc_next    = turn_count + 1'b1;
        turn_next  = turn_count[TURN_W-1:0];
      end
`ifdef HISTORY_WRAP_EN
      else if (btn_select) begin
        // Full ring: the write slot is the oldest slot, so drop it and advance.
        wr_en      = 1'b1;
        load_guess = 1'b1;
        wrap_en    = 1'b1;
        turn_next  = LAST_SLOT;
      end
`endif
      else if (turn_count == '0) begin
        turn_next = '0;
        clear_sel = 1'b1;
      end else begin
        // Idle guess mode (and a dropped select) keeps showing the newest turn.
        turn_next = tc_minus1;
        read_en   = 1'b1;
      end
    end else if (turn_count != '0) begin
      if (btn_up && !btn_down && selected_turn != tc_minus1)
        turn_next = selected_turn + 1'b1;
      else if (btn_down && !btn_up && selected_turn != '0)
        turn_next = selected_turn - 1'b1;
      read_en = 1'b1;
    end
  end

  // Storage, write pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      turn_count    <= '0;
      selected_turn <= '0;
      selection     <= '0;
      last_turn     <= 1'b0;
      full          <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= guess;
        wr_ptr      <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      turn_count    <= tc_next;
      selected_turn <= turn_next;
      if (load_guess)     selection <= guess;
      else if (read_en)   selection <= mem[read_slot];
      else if (clear_sel) selection <= '0;
      last_turn <= (tc_next == LAST_CNT);
      full      <= (tc_next == DEPTH_CNT);
    end
  end

`ifdef HISTORY_WRAP_EN
  // Oldest pointer follows each overwrite so logical turn 0 stays the oldest survivor.
  always_ff @(posedge clk) begin
    if (reset)        oldest_ptr <= '0;
    else if (wrap_en) oldest_ptr <= (oldest_ptr == LAST_SLOT) ? '0 : oldest_ptr + 1'b1;
  end
`else
  assign oldest_ptr = '0;
`endif

endmodule
